muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle controller/datapath for the ALU ops mul (aluCtrl=13), div (14), modulo (15).
//  Sits beside the single-cycle ALU; on start it freezes the processor via stall, runs an
//  iterative shift-add multiply or restoring divide, then returns the result with a done pulse.
//  All other aluCtrl codes are handled by the ALU and are ignored here.
// PARAMETERS
//  WIDTH     32   operand/result width in bits (>=4)
//  CNT_W     6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk         in   1        single clock, all state on rising edge
//  reset       in   1        synchronous, active-high
//  start       in   1        request; sampled only in IDLE
//  aluCtrl     in   4        operation code: 13 mul, 14 div, 15 modulo
//  srcA        in   WIDTH    multiplicand / dividend
//  srcB        in   WIDTH    multiplier / divisor
//  stall       out  1        combinational; holds PC and pipeline regs
//  busy        out  1        registered; high in RUN
//  done        out  1        registered; one-cycle pulse in DONE
//  result      out  WIDTH    product low WIDTH bits, quotient or remainder; held until next accept
//  divByZero   out  1        registered; valid with done, held with result
// BEHAVIOUR
//  - Reset (any state, incl. mid-operation): next edge -> IDLE; busy=0, done=0, result=0,
//    divByZero=0, counter=0, internal operand regs=0. stall then 0.
//  - Accept: IDLE & start & aluCtrl in {13,14,15}. Operands and op latched on that edge.
//    start with any other aluCtrl, or start in RUN/DONE: ignored, no state change.
//  - States: IDLE -(accept, srcB!=0 or mul)-> RUN ; IDLE -(accept div/mod, srcB==0)-> DONE ;
//    RUN -(counter==1 at edge)-> DONE ; RUN -(else)-> RUN, counter-1 ; DONE -> IDLE (always).
//  - counter loaded with WIDTH on accept; exactly one iteration per RUN cycle.
//  - Latency: accept at edge 0; busy=1 cycles 1..WIDTH; done=1 in cycle WIDTH+1 (33 for default).
//    Divide-by-zero: done=1 in cycle 1, no RUN cycles.
//  - stall = (IDLE & start & aluCtrl in {13..15}) | RUN. stall=0 in DONE so the instruction
//    retires and writes result back in the done cycle.
//  - Multiply: unsigned shift-add, 2*WIDTH accumulator; result = product[WIDTH-1:0] (wraps).
//  - Divide: restoring, WIDTH+1-bit partial remainder; div -> quotient, mod -> remainder.
//  - Div by zero: div result = all ones; mod result = srcA; divByZero=1. Mul never sets it.
//  - result/divByZero update only on the edge entering DONE; unchanged while IDLE/RUN.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined: operands two's complement. Magnitudes taken at accept, signs
//   applied on entering DONE: quotient negated if signs differ, remainder takes dividend sign,
//   product negated if signs differ. Overflow (MIN / -1): quotient=MIN, remainder=0,
//   divByZero=0. Latency identical to unsigned.
//  MULDIV_SIGNED_EN undefined: all operations unsigned; no sign logic synthesised.
// TESTING
//  1 reset, start=1 aluCtrl=13 A=7 B=6 -> stall=1 same cycle, busy cycles 1..32, done cycle 33, result=42
//  2 aluCtrl=14 A=100 B=7 -> done cycle 33, result=14; aluCtrl=15 same operands -> result=2
//  3 aluCtrl=14 A=5 B=0 -> done cycle 1, result=0xFFFFFFFF, divByZero=1; aluCtrl=15 -> result=5
//  4 mul in progress, reset=1 at cycle 10 -> cycle 11 busy=0 stall=0 done=0 result=0; no done pulse
//  5 start=1 aluCtrl=0 (add), and start=1 during RUN -> ignored, stall follows RUN only, one done
//  6 MULDIV_SIGNED_EN: A=-7 B=2 div -> 0xFFFFFFFD (-3); mod -> 0xFFFFFFFF (-1); mul -> -14

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the pipeline control and the multi-cycle mul/div sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       aluCtrl;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             divByZero;

  modport master (
    output start, aluCtrl, srcA, srcB,
    input  stall, busy, done, result, divByZero
  );

  modport slave (
    input  start, aluCtrl, srcA, srcB,
    output stall, busy, done, result, divByZero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider that stalls the pipeline while running.
// Build option: define MULDIV_SIGNED_EN for two's-complement operands (default is unsigned).
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave io_bus
);
  localparam logic [3:0] OP_MUL = 4'd13;
  localparam logic [3:0] OP_DIV = 4'd14;
  localparam logic [3:0] OP_MOD = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_mul;
  logic               r_is_mod;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_result;

  logic               w_op_ok;
  logic               w_accept;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_borrow;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_raw;
  logic [WIDTH-1:0]   w_final;

  assign w_op_ok  = (io_bus.aluCtrl == OP_MUL) || (io_bus.aluCtrl == OP_DIV) ||
                    (io_bus.aluCtrl == OP_MOD);
  assign w_accept = (r_state == S_IDLE) && io_bus.start && w_op_ok;
  assign w_b_zero = (io_bus.srcB == '0);

`ifdef MULDIV_SIGNED_EN
  // Iterate on magnitudes; the result sign is decided at accept and applied on the way out.
  logic r_neg_res;
  logic w_neg_a;
  logic w_neg_b;

  assign w_neg_a = io_bus.srcA[WIDTH-1];
  assign w_neg_b = io_bus.srcB[WIDTH-1];
  assign w_mag_a = w_neg_a ? WIDTH'(WIDTH'(0) - io_bus.srcA) : io_bus.srcA;
  assign w_mag_b = w_neg_b ? WIDTH'(WIDTH'(0) - io_bus.srcB) : io_bus.srcB;
  assign w_final = r_neg_res ? WIDTH'(WIDTH'(0) - w_raw) : w_raw;
`else
  assign w_mag_a = io_bus.srcA;
  assign w_mag_b = io_bus.srcB;
  assign w_final = w_raw;
`endif

  // One iteration: acc = {hi, lo}. Mul: hi accumulates, lo shifts out multiplier bits.
  // Div: hi is the partial remainder, lo shifts dividend out and quotient bits in.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_opnd};
  assign w_borrow  = w_diff[WIDTH];
  assign w_acc_nxt = r_is_mul ? {w_sum, r_acc[WIDTH-1:1]}
                              : {(w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                                 r_acc[WIDTH-2:0], ~w_borrow};
  assign w_raw     = r_is_mod ? w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[WIDTH-1:0];

  assign io_bus.stall     = w_accept || (r_state == S_RUN);
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.result    = r_result;
  assign io_bus.divByZero = r_dbz;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_is_mul <= 1'b0;
      r_is_mod <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_result <= '0;
`ifdef MULDIV_SIGNED_EN
      r_neg_res <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_mul <= (io_bus.aluCtrl == OP_MUL);
            r_is_mod <= (io_bus.aluCtrl == OP_MOD);
            r_cnt    <= CNT_W'(WIDTH);
            if (io_bus.aluCtrl == OP_MUL) begin
              r_opnd <= w_mag_a;
              r_acc  <= {WIDTH'(0), w_mag_b};
            end else begin
              r_opnd <= w_mag_b;
              r_acc  <= {WIDTH'(0), w_mag_a};
            end
`ifdef MULDIV_SIGNED_EN
            r_neg_res <= (io_bus.aluCtrl == OP_MOD) ? w_neg_a : (w_neg_a ^ w_neg_b);
`endif
            if ((io_bus.aluCtrl != OP_MUL) && w_b_zero) begin
              // Zero divisor short-circuits straight to DONE with fixed results.
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_dbz    <= 1'b1;
              r_result <= (io_bus.aluCtrl == OP_MOD) ? io_bus.srcA : '1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_dbz    <= 1'b0;
            r_result <= w_final;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected results queued at issue, checked on done.
module tb_muldiv_sequencer;
  localparam int unsigned WIDTH = 32;
  localparam logic [3:0] OP_MUL = 4'd13;
  localparam logic [3:0] OP_DIV = 4'd14;
  localparam logic [3:0] OP_MOD = 4'd15;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             dbz;
    int               lat;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];
  logic [WIDTH-1:0] last_res;

  muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

  muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
    exp_t e;
    logic [WIDTH-1:0] min_v;
    min_v = '0;
    min_v[WIDTH-1] = 1'b1;
    e.dbz = 1'b0;
    e.lat = WIDTH + 1;
    if (op == OP_MUL) begin
      e.res = WIDTH'(a * b);
    end else if (b == '0) begin
      e.res = (op == OP_DIV) ? '1 : a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
`ifdef MULDIV_SIGNED_EN
      if (a == min_v && b == '1) e.res = (op == OP_DIV) ? min_v : '0;
      else e.res = (op == OP_DIV) ? WIDTH'($signed(a) / $signed(b))
                                  : WIDTH'($signed(a) % $signed(b));
`else
      e.res = (op == OP_DIV) ? a / b : a % b;
`endif
    end
    return e;
  endfunction

  // Issue one op, track busy/stall/done per cycle, compare against the scoreboard on done.
  task automatic run_op(input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit inject);
    exp_t e;
    exp_t got_e;
    bit   seen;
    e = model(op, a, b);
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b1; bus.aluCtrl = op; bus.srcA = a; bus.srcB = b;
    #1;
    check("stall_accept", bus.stall, 1'b1);
    check("result_held_accept", bus.result, last_res);
    @(negedge clk);
    bus.start = 1'b0; bus.aluCtrl = 4'd0; bus.srcA = $urandom; bus.srcB = $urandom;
    seen = 1'b0;
    for (int k = 1; k <= int'(WIDTH) + 4 && !seen; k++) begin
      if (inject && k >= 5 && k <= 10) begin
        bus.start = 1'b1; bus.aluCtrl = OP_DIV;
      end else begin
        bus.start = 1'b0; bus.aluCtrl = 4'd0;
      end
      #1;
      check("busy", bus.busy, (k < e.lat));
      check("stall", bus.stall, (k < e.lat));
      check("done", bus.done, (k == e.lat));
      if (bus.done === 1'b1) begin
        seen  = 1'b1;
        got_e = sb_q.pop_front();
        check("result", bus.result, got_e.res);
        check("divByZero", bus.divByZero, got_e.dbz);
        last_res = got_e.res;
      end else if (k < e.lat) begin
        check("result_held_run", bus.result, last_res);
      end
      @(negedge clk);
    end
    if (!seen) begin
      check("done_timeout", 1'b0, 1'b1);
      void'(sb_q.pop_front());
    end
    bus.start = 1'b0;
    #1;
    check("done_pulse_end", bus.done, 1'b0);
    check("busy_after", bus.busy, 1'b0);
    check("result_hold", bus.result, last_res);
  endtask

  task automatic ignored_start;
    @(negedge clk);
    bus.start = 1'b1; bus.aluCtrl = 4'd0; bus.srcA = 32'd3; bus.srcB = 32'd4;
    #1;
    check("stall_ignored", bus.stall, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("busy_ignored", bus.busy, 1'b0);
      check("done_ignored", bus.done, 1'b0);
      check("result_ignored", bus.result, last_res);
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_op;
    int pulses;
    @(negedge clk);
    bus.start = 1'b1; bus.aluCtrl = OP_MUL; bus.srcA = 32'd9; bus.srcB = 32'd9;
    @(negedge clk);
    bus.start = 1'b0; bus.aluCtrl = 4'd0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    check("busy_before_reset", bus.busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_stall", bus.stall, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 32'd0);
    check("rst_dbz", bus.divByZero, 1'b0);
    last_res = '0;
    pulses = 0;
    for (int k = 0; k < int'(WIDTH) + 8; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    check("no_done_after_reset", 64'(pulses), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_res = '0;
    reset = 1'b1;
    bus.start = 1'b0; bus.aluCtrl = 4'd0; bus.srcA = '0; bus.srcB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_stall", bus.stall, 1'b0);
    check("reset_result", bus.result, 32'd0);
    check("reset_dbz", bus.divByZero, 1'b0);
    reset = 1'b0;

    run_op(OP_MUL, 32'd7, 32'd6, 1'b0);
    run_op(OP_DIV, 32'd100, 32'd7, 1'b0);
    run_op(OP_MOD, 32'd100, 32'd7, 1'b0);
    run_op(OP_DIV, 32'd5, 32'd0, 1'b0);
    run_op(OP_MOD, 32'd5, 32'd0, 1'b0);
    run_op(OP_MUL, 32'h0000_0000, 32'h0000_0000, 1'b0);
    run_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);
    run_op(OP_DIV, 32'd3, 32'd10, 1'b0);
    run_op(OP_MOD, 32'd3, 32'd10, 1'b0);
    run_op(OP_DIV, 32'h8000_0000, 32'd1, 1'b0);
    run_op(OP_MOD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    ignored_start();
    run_op(OP_MUL, 32'd11, 32'd13, 1'b1);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] op;
      op = 4'(13 + $urandom_range(0, 2));
      run_op(op, $urandom, 32'($urandom_range(1, 1000)), 1'b0);
    end
`ifdef MULDIV_SIGNED_EN
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(OP_MOD, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(OP_MUL, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_MOD, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_MOD, 32'hFFFF_FFF9, 32'd0, 1'b0);
`else
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFFF, 32'd1, 1'b0);
`endif
    reset_mid_op();
    run_op(OP_MOD, 32'd1000, 32'd33, 1'b0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end
endmodule
